otter_decode_stage: RTL and testbench

Registered, stall-aware instruction decode stage for the pipelined OTTER core, located between the IF/ID and ID/EX pipeline boundaries. Each cycle it decodes one RV32I instruction, with optional M-extension, into datapath control fields and registers them as the ID/EX control bundle. It detects load-use hazards and inserts a parametrised number of bubbles, and it squashes its contents on branch flush or interrupt.

---
 rtl/otter_pkg.sv | 53 +++++
 rtl/otter_decode_stage_if.sv | 46 ++++
 rtl/otter_ctrl_decode.sv | 87 ++++++++
 rtl/otter_decode_stage.sv | 132 +++++++++++++
 tb/tb_otter_decode_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode and SYSTEM funct3 encodings, ALU function codes.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_system_t;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b1000;
    localparam logic [3:0] ALU_SLL      = 4'b0001;
    localparam logic [3:0] ALU_SLT      = 4'b0010;
    localparam logic [3:0] ALU_SLTU     = 4'b0011;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_SRL      = 4'b0101;
    localparam logic [3:0] ALU_SRA      = 4'b1101;
    localparam logic [3:0] ALU_OR       = 4'b0110;
    localparam logic [3:0] ALU_AND      = 4'b0111;
    localparam logic [3:0] ALU_LUI_COPY = 4'b1001;

    localparam logic [4:0] ALU_MUL    = 5'b10000;
    localparam logic [4:0] ALU_MULH   = 5'b10001;
    localparam logic [4:0] ALU_MULHSU = 5'b10010;
    localparam logic [4:0] ALU_MULHU  = 5'b10011;
    localparam logic [4:0] ALU_DIV    = 5'b10100;
    localparam logic [4:0] ALU_DIVU   = 5'b10101;
    localparam logic [4:0] ALU_REM    = 5'b10110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;

    // Register-form CSR ops and privileged ops read rs1; immediate CSR forms do not.
    function automatic logic sys_reads_rs1(funct3_system_t f3);
        return f3 inside {F3_PRIV, F3_CSRRW, F3_CSRRS, F3_CSRRC};
    endfunction

endpackage

// File: rtl/otter_decode_stage_if.sv
// IF/ID input side and ID/EX control bundle of the OTTER decode stage.
interface otter_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int EN_M = 0
);
    localparam int ALU_FUN_W = (EN_M != 0) ? 5 : 4;

    logic                 IF_VALID;
    logic [31:0]          IF_INSTR;
    logic [XLEN-1:0]      IF_PC;
    logic                 ID_READY;
    logic                 EX_READY;
    logic                 FLUSH;
    logic                 INT_TAKEN;
    logic                 ID_VALID;
    logic [XLEN-1:0]      ID_PC;
    logic [4:0]           ID_RS1;
    logic [4:0]           ID_RS2;
    logic [4:0]           ID_RD;
    logic [2:0]           ID_FUNC3;
    logic                 ID_ALU_SRCA;
    logic [1:0]           ID_ALU_SRCB;
    logic [ALU_FUN_W-1:0] ID_ALU_FUN;
    logic [1:0]           ID_RF_WR_SEL;
    logic                 ID_REG_WRITE;
    logic                 ID_MEM_WRITE;
    logic                 ID_MEM_READ2;
    logic                 ID_BRANCH;
    logic                 ID_JUMP;
    logic                 ID_ILLEGAL;
    logic                 HAZARD_STALL;

    modport master (
        output IF_VALID, IF_INSTR, IF_PC, EX_READY, FLUSH, INT_TAKEN,
        input  ID_READY, ID_VALID, ID_PC, ID_RS1, ID_RS2, ID_RD, ID_FUNC3,
               ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL, ID_REG_WRITE,
               ID_MEM_WRITE, ID_MEM_READ2, ID_BRANCH, ID_JUMP, ID_ILLEGAL, HAZARD_STALL
    );

    modport slave (
        input  IF_VALID, IF_INSTR, IF_PC, EX_READY, FLUSH, INT_TAKEN,
        output ID_READY, ID_VALID, ID_PC, ID_RS1, ID_RS2, ID_RD, ID_FUNC3,
               ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL, ID_REG_WRITE,
               ID_MEM_WRITE, ID_MEM_READ2, ID_BRANCH, ID_JUMP, ID_ILLEGAL, HAZARD_STALL
    );
endinterface

// File: rtl/otter_ctrl_decode.sv
// Combinational RV32I(+M) control decoder: instruction in, control fields and rs-use flags out.
module otter_ctrl_decode
    import otter_pkg::*;
#(
    parameter int EN_M      = 0,
    parameter int ALU_FUN_W = (EN_M != 0) ? 5 : 4
) (
    input  logic [31:0]          instr,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [2:0]           func3,
    output logic                 alu_srca,
    output logic [1:0]           alu_srcb,
    output logic [ALU_FUN_W-1:0] alu_fun,
    output logic [1:0]           rf_wr_sel,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 mem_read2,
    output logic                 branch,
    output logic                 jump,
    output logic                 illegal,
    output logic                 rs1_used,
    output logic                 rs2_used
);
    opcode_t    opcode;
    logic [6:0] f7;
    logic       is_mext;
    logic [4:0] alu5;

    assign opcode  = opcode_t'(instr[6:0]);
    assign rd      = instr[11:7];
    assign func3   = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign f7      = instr[31:25];
    assign is_mext = (EN_M != 0) && (f7 == 7'b0000001);

    always_comb begin
        alu5      = '0;
        alu_srca  = 1'b0;
        alu_srcb  = 2'd0;
        rf_wr_sel = 2'd3;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read2 = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        case (opcode)
            LUI:    begin alu5 = {1'b0, ALU_LUI_COPY}; alu_srca = 1'b1; reg_write = 1'b1; end
            AUIPC:  begin alu_srca = 1'b1; alu_srcb = 2'd3; reg_write = 1'b1; end
            JAL:    begin rf_wr_sel = 2'd0; alu_srcb = 2'd1; reg_write = 1'b1; jump = 1'b1; end
            JALR:   begin rf_wr_sel = 2'd0; reg_write = 1'b1; jump = 1'b1; rs1_used = 1'b1; end
            BRANCH: begin branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
            LOAD:   begin
                rf_wr_sel = 2'd2; alu_srcb = 2'd1; reg_write = 1'b1; mem_read2 = 1'b1;
                rs1_used  = 1'b1;
            end
            STORE:  begin alu_srcb = 2'd2; mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_IMM: begin
                // Only shift-right immediates carry the arithmetic/logical select in f7[5].
                alu5      = (func3 == 3'b101) ? {1'b0, f7[5], func3} : {2'b00, func3};
                alu_srcb  = 2'd1;
                reg_write = 1'b1;
                rs1_used  = 1'b1;
            end
            OP:     begin
                alu5      = is_mext ? {ALU_MUL[4:3], func3} : {1'b0, f7[5], func3};
                reg_write = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            SYSTEM: begin
                alu5      = {1'b0, ALU_LUI_COPY};
                rf_wr_sel = 2'd1;
                rs1_used  = sys_reads_rs1(funct3_system_t'(func3));
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_fun = alu5[ALU_FUN_W-1:0];

endmodule

// File: rtl/otter_decode_stage.sv
// OTTER ID stage: decodes IF_INSTR into the registered ID/EX control bundle,
// inserts LOAD_LAT bubbles per load-use hazard and squashes on flush/interrupt.
module otter_decode_stage
    import otter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_M     = 0,
    parameter int LOAD_LAT = 1
) (
    input logic              CLK,
    input logic              RST,
    otter_decode_stage_if.slave bus
);
    localparam int ALU_FUN_W = (EN_M != 0) ? 5 : 4;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [2:0]           func3;
        logic                 alu_srca;
        logic [1:0]           alu_srcb;
        logic [ALU_FUN_W-1:0] alu_fun;
        logic [1:0]           rf_wr_sel;
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem_read2;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } bundle_t;

    localparam bundle_t BUBBLE = '{rf_wr_sel: 2'd3, default: '0};

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_next;
    logic [1:0] cnt, cnt_next;
    bundle_t    id_q, id_d, dec;
    logic       rs1_used, rs2_used;
    logic       squash, hazard;

    otter_ctrl_decode #(
        .EN_M      (EN_M),
        .ALU_FUN_W (ALU_FUN_W)
    ) u_ctrl (
        .instr     (bus.IF_INSTR),
        .rs1       (dec.rs1),
        .rs2       (dec.rs2),
        .rd        (dec.rd),
        .func3     (dec.func3),
        .alu_srca  (dec.alu_srca),
        .alu_srcb  (dec.alu_srcb),
        .alu_fun   (dec.alu_fun),
        .rf_wr_sel (dec.rf_wr_sel),
        .reg_write (dec.reg_write),
        .mem_write (dec.mem_write),
        .mem_read2 (dec.mem_read2),
        .branch    (dec.branch),
        .jump      (dec.jump),
        .illegal   (dec.illegal),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used)
    );

    assign dec.valid = 1'b1;
    assign dec.pc    = bus.IF_PC;

    assign squash = bus.FLUSH | bus.INT_TAKEN;
    assign hazard = bus.IF_VALID & id_q.valid & id_q.mem_read2 & (id_q.rd != '0)
                  & ((rs1_used & (dec.rs1 == id_q.rd)) | (rs2_used & (dec.rs2 == id_q.rd)));

    // The hazard cycle itself supplies the first bubble, so STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        id_d       = id_q;
        if (squash) begin
            id_d       = BUBBLE;
            state_next = RUN;
            cnt_next   = '0;
        end else if (bus.EX_READY) begin
            if (state == STALL) begin
                id_d     = BUBBLE;
                cnt_next = cnt - 2'd1;
                if (cnt == 2'd1) state_next = RUN;
            end else if (hazard) begin
                id_d = BUBBLE;
                if (LOAD_LAT > 1) begin
                    state_next = STALL;
                    cnt_next   = 2'(LOAD_LAT - 1);
                end
            end else begin
                id_d = bus.IF_VALID ? dec : BUBBLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            cnt   <= '0;
            id_q  <= BUBBLE;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            id_q  <= id_d;
        end
    end

    assign bus.ID_READY     = (bus.EX_READY & (state == RUN) & ~hazard) | squash;
    assign bus.HAZARD_STALL = hazard | (state == STALL);
    assign bus.ID_VALID     = id_q.valid;
    assign bus.ID_PC        = id_q.pc;
    assign bus.ID_RS1       = id_q.rs1;
    assign bus.ID_RS2       = id_q.rs2;
    assign bus.ID_RD        = id_q.rd;
    assign bus.ID_FUNC3     = id_q.func3;
    assign bus.ID_ALU_SRCA  = id_q.alu_srca;
    assign bus.ID_ALU_SRCB  = id_q.alu_srcb;
    assign bus.ID_ALU_FUN   = id_q.alu_fun;
    assign bus.ID_RF_WR_SEL = id_q.rf_wr_sel;
    assign bus.ID_REG_WRITE = id_q.reg_write;
    assign bus.ID_MEM_WRITE = id_q.mem_write;
    assign bus.ID_MEM_READ2 = id_q.mem_read2;
    assign bus.ID_BRANCH    = id_q.branch;
    assign bus.ID_JUMP      = id_q.jump;
    assign bus.ID_ILLEGAL   = id_q.illegal;

endmodule

// File: tb/tb_otter_decode_stage.sv
// Bench for otter_decode_stage: two instances (EN_M=0/LOAD_LAT=1 and EN_M=1/LOAD_LAT=3)
// share one stimulus stream and are each compared with a cycle-level reference model.
module tb_otter_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        srca;
        logic [1:0]  srcb;
        logic [4:0]  alu;
        logic [1:0]  wsel;
        logic        rw, mw, mr, br, jmp, ill;
    } exp_t;

    localparam exp_t BUB = '{wsel: 2'd3, default: '0};

    logic        clk = 1'b0;
    logic        s_rst, s_valid, s_ex, s_flush, s_int;
    logic [31:0] s_instr, s_pc;
    int          sel;
    logic        acc;
    int          n_cmp = 0;
    int          n_err = 0;

    exp_t m_b[2];
    int   m_left[2];
    int   lat[2] = '{1, 3};
    bit   enm[2] = '{1'b0, 1'b1};
    bit   hz_s[2];

    always #5 clk = ~clk;

    otter_decode_stage_if #(.XLEN(32), .EN_M(0)) if_a ();
    otter_decode_stage_if #(.XLEN(32), .EN_M(1)) if_b ();

    assign if_a.IF_VALID = s_valid;  assign if_b.IF_VALID = s_valid;
    assign if_a.IF_INSTR = s_instr;  assign if_b.IF_INSTR = s_instr;
    assign if_a.IF_PC    = s_pc;     assign if_b.IF_PC    = s_pc;
    assign if_a.EX_READY = s_ex;     assign if_b.EX_READY = s_ex;
    assign if_a.FLUSH    = s_flush;  assign if_b.FLUSH    = s_flush;
    assign if_a.INT_TAKEN = s_int;   assign if_b.INT_TAKEN = s_int;

    otter_decode_stage #(.XLEN(32), .EN_M(0), .LOAD_LAT(1)) dut_a (.CLK(clk), .RST(s_rst), .bus(if_a));
    otter_decode_stage #(.XLEN(32), .EN_M(1), .LOAD_LAT(3)) dut_b (.CLK(clk), .RST(s_rst), .bus(if_b));

    task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Control table as listed for each RV32I opcode.
    function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] pc, bit m);
        exp_t e = BUB;
        e.valid = 1'b1; e.pc = pc; e.rd = i[11:7]; e.f3 = i[14:12];
        e.rs1 = i[19:15]; e.rs2 = i[24:20];
        case (i[6:0])
            7'h37: begin e.alu = 5'd9; e.srca = 1; e.rw = 1; end
            7'h17: begin e.srca = 1; e.srcb = 3; e.rw = 1; end
            7'h6F: begin e.wsel = 0; e.srcb = 1; e.rw = 1; e.jmp = 1; end
            7'h67: begin e.wsel = 0; e.rw = 1; e.jmp = 1; end
            7'h63: e.br = 1;
            7'h03: begin e.wsel = 2; e.srcb = 1; e.rw = 1; e.mr = 1; end
            7'h23: begin e.srcb = 2; e.mw = 1; end
            7'h13: begin
                e.srcb = 1; e.rw = 1;
                e.alu = (i[14:12] == 3'd5) ? {1'b0, i[30], i[14:12]} : {2'b0, i[14:12]};
            end
            7'h33: begin
                e.rw = 1;
                e.alu = (m && i[31:25] == 7'd1) ? {2'b10, i[14:12]} : {1'b0, i[30], i[14:12]};
            end
            7'h73: begin e.wsel = 1; e.alu = 5'd9; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic bit ref_hz(int d);
        bit u1, u2;
        logic [6:0] op = s_instr[6:0];
        u1 = (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33}) || (op == 7'h73 && !s_instr[14]);
        u2 = op inside {7'h63, 7'h23, 7'h33};
        return s_valid && m_b[d].valid && m_b[d].mr && (m_b[d].rd != 5'd0)
            && ((u1 && s_instr[19:15] == m_b[d].rd) || (u2 && s_instr[24:20] == m_b[d].rd));
    endfunction

    task automatic upd(int d);
        if (s_rst || s_flush || s_int) begin m_b[d] = BUB; m_left[d] = 0; end
        else if (!s_ex) begin end
        else if (m_left[d] > 0) begin m_b[d] = BUB; m_left[d]--; end
        else if (hz_s[d]) begin m_b[d] = BUB; m_left[d] = lat[d] - 1; end
        else if (!s_valid) m_b[d] = BUB;
        else m_b[d] = ref_dec(s_instr, s_pc, enm[d]);
    endtask

    function automatic exp_t obs(int d);
        exp_t o;
        if (d == 0) begin
            o.valid = if_a.ID_VALID; o.pc = if_a.ID_PC; o.rs1 = if_a.ID_RS1; o.rs2 = if_a.ID_RS2;
            o.rd = if_a.ID_RD; o.f3 = if_a.ID_FUNC3; o.srca = if_a.ID_ALU_SRCA;
            o.srcb = if_a.ID_ALU_SRCB; o.alu = {1'b0, if_a.ID_ALU_FUN}; o.wsel = if_a.ID_RF_WR_SEL;
            o.rw = if_a.ID_REG_WRITE; o.mw = if_a.ID_MEM_WRITE; o.mr = if_a.ID_MEM_READ2;
            o.br = if_a.ID_BRANCH; o.jmp = if_a.ID_JUMP; o.ill = if_a.ID_ILLEGAL;
        end else begin
            o.valid = if_b.ID_VALID; o.pc = if_b.ID_PC; o.rs1 = if_b.ID_RS1; o.rs2 = if_b.ID_RS2;
            o.rd = if_b.ID_RD; o.f3 = if_b.ID_FUNC3; o.srca = if_b.ID_ALU_SRCA;
            o.srcb = if_b.ID_ALU_SRCB; o.alu = if_b.ID_ALU_FUN; o.wsel = if_b.ID_RF_WR_SEL;
            o.rw = if_b.ID_REG_WRITE; o.mw = if_b.ID_MEM_WRITE; o.mr = if_b.ID_MEM_READ2;
            o.br = if_b.ID_BRANCH; o.jmp = if_b.ID_JUMP; o.ill = if_b.ID_ILLEGAL;
        end
        return o;
    endfunction

    // One clock: check handshake outputs mid-cycle, advance the models, check the bundle.
    task automatic tick();
        logic [1:0] r, h;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            hz_s[d] = ref_hz(d);
            r[d] = (s_ex && m_left[d] == 0 && !hz_s[d]) || s_flush || s_int;
            h[d] = hz_s[d] || (m_left[d] > 0);
        end
        chk("ready_a", 96'(if_a.ID_READY), 96'(r[0]));
        chk("ready_b", 96'(if_b.ID_READY), 96'(r[1]));
        chk("hzst_a", 96'(if_a.HAZARD_STALL), 96'(h[0]));
        chk("hzst_b", 96'(if_b.HAZARD_STALL), 96'(h[1]));
        acc = (sel == 0) ? if_a.ID_READY : if_b.ID_READY;
        @(posedge clk);
        for (int d = 0; d < 2; d++) upd(d);
        #1;
        chk("bundle_a", 96'(obs(0)), 96'(m_b[0]));
        chk("bundle_b", 96'(obs(1)), 96'(m_b[1]));
    endtask

    task automatic feed(input logic [31:0] ins, output int n);
        s_valid = 1'b1; s_instr = ins; n = 0;
        do begin tick(); n++; end while (!acc && n < 20);
        if (!acc) begin
            n_cmp++; n_err++;
            $error("FAIL feed_timeout: instr=%h not accepted within %0d cycles", ins, n);
        end
        s_pc = s_pc + 32'd4;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        int k = $urandom_range(0, 10);
        logic [6:0] op = (k == 10) ? 7'($urandom) : ops[k];
        logic [6:0] f7 = f7s[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        int n;
        s_rst = 1'b1; s_valid = 1'b0; s_ex = 1'b1; s_flush = 1'b0; s_int = 1'b0;
        s_instr = '0; s_pc = 32'h100; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin m_b[d] = BUB; m_left[d] = 0; end
        tick();
        chk("rst_valid", 96'(if_b.ID_VALID), 96'(0));
        chk("rst_wsel", 96'(if_b.ID_RF_WR_SEL), 96'(3));
        s_rst = 1'b0;

        // addi then add with no dependency on a load
        feed(32'h00500093, n);
        chk("addi_alu", 96'(if_a.ID_ALU_FUN), 96'(0));
        chk("addi_srcb", 96'(if_a.ID_ALU_SRCB), 96'(1));
        chk("addi_rw", 96'(if_a.ID_REG_WRITE), 96'(1));
        feed(32'h001080B3, n);
        chk("add_srcb", 96'(if_a.ID_ALU_SRCB), 96'(0));
        chk("add_nostall", 96'(n), 96'(1));

        // load-use: one bubble at LOAD_LAT=1, three at LOAD_LAT=3
        idle(4);
        feed(32'h0000A103, n);
        feed(32'h00210133, n);
        chk("lat1_cycles", 96'(n), 96'(2));
        sel = 1;
        idle(4);
        feed(32'h0000A103, n);
        feed(32'h00210133, n);
        chk("lat3_cycles", 96'(n), 96'(4));

        // load to x0 never stalls
        idle(4);
        feed(32'h00002003, n);
        feed(32'h000000B3, n);
        chk("x0_nostall", 96'(n), 96'(1));

        // flush on the second stall cycle
        idle(4);
        feed(32'h0000A103, n);
        s_valid = 1'b1; s_instr = 32'h00210133;
        tick();
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        chk("flush_valid", 96'(if_b.ID_VALID), 96'(0));
        chk("flush_run", 96'(if_b.HAZARD_STALL), 96'(0));
        feed(32'h00210133, n);
        chk("flush_accept", 96'(n), 96'(1));

        // EX back-pressure holds a valid bundle
        idle(4);
        feed(32'h00500093, n);
        s_ex = 1'b0; s_valid = 1'b1; s_instr = 32'h001080B3;
        repeat (4) begin
            tick();
            chk("exlow_ready", 96'(if_b.ID_READY), 96'(0));
            chk("exlow_valid", 96'(if_b.ID_VALID), 96'(1));
        end
        s_ex = 1'b1; s_valid = 1'b0;

        // M-extension and illegal opcode
        idle(4);
        feed(32'h02208033, n);
        chk("mul_m0", 96'(if_a.ID_ALU_FUN), 96'(0));
        chk("mul_m1", 96'(if_b.ID_ALU_FUN), 96'(5'b10000));
        feed(32'h0000007F, n);
        chk("ill_flag", 96'(if_b.ID_ILLEGAL), 96'(1));
        chk("ill_rw", 96'(if_b.ID_REG_WRITE), 96'(0));

        // random traffic with back-pressure, squashes and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 99) < 85);
            s_instr = rnd_instr();
            s_pc    = $urandom & 32'hFFFF_FFFC;
            s_ex    = ($urandom_range(0, 99) < 80);
            s_flush = ($urandom_range(0, 99) < 5);
            s_int   = ($urandom_range(0, 99) < 3);
            s_rst   = (i == 200);
            tick();
        end
        s_rst = 1'b0; s_flush = 1'b0; s_int = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
